// File: rtl/dds_wave_gen_pkg.sv
// dds_pkg: shared mode codes, FSM state encoding and the mode type for the
// phase-accumulator waveform generator (dds_wave_gen).
package dds_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SAW = 2'd0;
    localparam mode_t MODE_TRI = 2'd1;
    localparam mode_t MODE_SQR = 2'd2;
    localparam mode_t MODE_DC  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

endpackage

// File: rtl/dds_wave_gen_if.sv
// dds_wave_gen_if: configuration port of dds_wave_gen.
// Handshake: a transfer happens on a rising clk edge where cfg_valid and
// cfg_ready are both high; cfg_step/cfg_phase/cfg_mode are sampled on that
// edge. cfg_valid while cfg_ready is low is simply ignored (no queueing), so
// the master may drop or change its offer at any time.
interface dds_wave_gen_if
    import dds_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 12
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [ACC_W-1:0]   cfg_step;
    logic [PHASE_W-1:0] cfg_phase;
    mode_t              cfg_mode;

    modport master (
        output cfg_valid, cfg_step, cfg_phase, cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_step, cfg_phase, cfg_mode,
        output cfg_ready
    );
endinterface

// File: rtl/dds_wave_shaper.sv
// dds_wave_shaper: maps a registered phase word to an output sample
// (saw / triangle / square / DC midscale) and holds it in the stage-2
// register. The register only loads for samples from enabled cycles.
module dds_wave_shaper
    import dds_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [ACC_W-1:0] p_i,
    input  mode_t            mode_i,
    output logic [OUT_W-1:0] wave_o
);
    logic             msb;
    logic [OUT_W-1:0] saw;
    logic [OUT_W-1:0] tri_t;
    logic [OUT_W-1:0] shaped;
    logic [OUT_W-1:0] wave_q;

    // Phase-to-amplitude mapping taken straight from the phase bits.
    always_comb begin
        shaped = '0;
        msb    = p_i[ACC_W-1];
        saw    = p_i[ACC_W-1 -: OUT_W];
        tri_t  = p_i[ACC_W-2 -: OUT_W];
        case (mode_i)
            MODE_SAW: shaped = saw;
            MODE_TRI: shaped = msb ? ~tri_t : tri_t;
            MODE_SQR: shaped = {OUT_W{msb}};
            default:  shaped = {1'b1, {(OUT_W-1){1'b0}}};
        endcase
    end

    // Phase bits below the triangle slice never reach the output.
    generate
        if (ACC_W > OUT_W + 1) begin : g_low_bits
            logic unused_low;
            assign unused_low = ^p_i[ACC_W-OUT_W-2:0];
        end
    endgenerate

    // Stage 2: hold the last sample while no enabled sample arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            wave_q <= '0;
        end else if (en_i) begin
            wave_q <= shaped;
        end
    end

    assign wave_o = wave_q;
endmodule

// File: rtl/dds_wave_gen.sv
// dds_wave_gen: phase-accumulator waveform generator with a valid/ready
// config port. New step/phase/mode land glitch-free at an accumulator wrap.
// Optional build macro DDS_SYNC_OUT_EN adds the sync_out pulse output.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 12,
    parameter int OUT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    dds_wave_gen_if.slave    cfg,
    output logic [OUT_W-1:0] wave_out,
    output logic             out_valid,
    output state_t           state_o
`ifdef DDS_SYNC_OUT_EN
    ,
    output logic             sync_out
`endif
);
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   step_q;
    logic [PHASE_W-1:0] phase_q;
    mode_t              mode_q;
    logic [ACC_W-1:0]   sh_step_q;
    logic [PHASE_W-1:0] sh_phase_q;
    mode_t              sh_mode_q;
    logic               cfg_ready_q;
    state_t             state_q;

    logic [ACC_W-1:0]   p1_q;
    mode_t              mode1_q;
    logic               en1_q;
    logic               out_valid_q;

    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   phase_ext;
    logic               xfer;
    logic               wrap;
    logic               pend_apply;
    logic               direct_apply;

    // Carry out of acc+step marks a wrap; pending configs may only land then
    // (or at once when a wrap can no longer happen).
    always_comb begin
        sum          = {1'b0, acc_q} + {1'b0, step_q};
        phase_ext    = {phase_q, {(ACC_W-PHASE_W){1'b0}}};
        xfer         = cfg.cfg_valid & cfg_ready_q;
        wrap         = enable & sum[ACC_W];
        pend_apply   = (state_q == PENDING) & (~enable | wrap | (step_q == '0));
        direct_apply = (state_q != PENDING) & ~enable & xfer;
    end

    // Accumulator, config shadow/active registers and the handshake FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            step_q      <= '0;
            phase_q     <= '0;
            mode_q      <= MODE_SAW;
            sh_step_q   <= '0;
            sh_phase_q  <= '0;
            sh_mode_q   <= MODE_SAW;
            cfg_ready_q <= 1'b1;
            state_q     <= IDLE;
        end else begin
            if (enable) begin
                acc_q <= sum[ACC_W-1:0];
            end
            if (pend_apply) begin
                step_q      <= sh_step_q;
                phase_q     <= sh_phase_q;
                mode_q      <= sh_mode_q;
                cfg_ready_q <= 1'b1;
                state_q     <= enable ? RUN : IDLE;
            end else if (direct_apply) begin
                step_q  <= cfg.cfg_step;
                phase_q <= cfg.cfg_phase;
                mode_q  <= cfg.cfg_mode;
                state_q <= IDLE;
            end else if (state_q != PENDING) begin
                if (enable && xfer) begin
                    sh_step_q   <= cfg.cfg_step;
                    sh_phase_q  <= cfg.cfg_phase;
                    sh_mode_q   <= cfg.cfg_mode;
                    cfg_ready_q <= 1'b0;
                    state_q     <= PENDING;
                end else begin
                    state_q <= enable ? RUN : IDLE;
                end
            end
        end
    end

    // Stage 1: register the offset phase and its mode; track sample validity.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_q        <= '0;
            mode1_q     <= MODE_SAW;
            en1_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            p1_q        <= acc_q + phase_ext;
            mode1_q     <= mode_q;
            en1_q       <= enable;
            out_valid_q <= en1_q;
        end
    end

    dds_wave_shaper #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
    ) u_shaper (
        .clk   (clk),
        .reset (reset),
        .en_i  (en1_q),
        .p_i   (p1_q),
        .mode_i(mode1_q),
        .wave_o(wave_out)
    );

    assign cfg.cfg_ready = cfg_ready_q;
    assign out_valid     = out_valid_q;
    assign state_o       = state_q;

`ifdef DDS_SYNC_OUT_EN
    logic mark_q;
    logic sync1_q;
    logic sync_q;

    // Tag the first accumulator value after a wrap or apply and carry the
    // tag alongside its sample through both pipeline stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            mark_q  <= 1'b0;
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            mark_q  <= enable ? (wrap | pend_apply | direct_apply)
                              : (mark_q | pend_apply | direct_apply);
            sync1_q <= mark_q & enable;
            sync_q  <= sync1_q;
        end
    end

    assign sync_out = sync_q;
`endif
endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: self-checking bench for dds_wave_gen at ACC_W=12,
// PHASE_W=4, OUT_W=8. Directed table, hand sequences and random traffic
// checked against an arithmetic reference model.
module tb_dds_wave_gen;
    import dds_pkg::*;

    localparam int ACC_W   = 12;
    localparam int PHASE_W = 4;
    localparam int OUT_W   = 8;
    localparam int MODV    = 1 << ACC_W;
    localparam int HALF    = 1 << (ACC_W - 1);

    typedef struct {
        int step;
        int phase;
        int mode;
        int exp0;
        int exp1;
        int exp2;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic [OUT_W-1:0] wave_out;
    logic out_valid;
    state_t state;
`ifdef DDS_SYNC_OUT_EN
    logic sync_out;
`endif

    always #5 clk = ~clk;

    dds_wave_gen_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W)) cfg_bus ();

    dds_wave_gen #(
        .ACC_W(ACC_W),
        .PHASE_W(PHASE_W),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .reset    (rst),
        .enable   (enable),
        .cfg      (cfg_bus.slave),
        .wave_out (wave_out),
        .out_valid(out_valid),
        .state_o  (state)
`ifdef DDS_SYNC_OUT_EN
        ,
        .sync_out (sync_out)
`endif
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    logic [OUT_W-1:0] exp_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int shape(input int p, input int mode);
        int t;
        t = (p % HALF) / (1 << (ACC_W - 1 - OUT_W));
        case (mode)
            0: return p / (1 << (ACC_W - OUT_W));
            1: return (p >= HALF) ? ((1 << OUT_W) - 1 - t) : t;
            2: return (p >= HALF) ? ((1 << OUT_W) - 1) : 0;
            default: return 1 << (OUT_W - 1);
        endcase
    endfunction

    int m_acc, m_step, m_phase, m_mode;
    int sh_step, sh_phase, sh_mode;
    bit m_pend, m_ready, m_en1, m_valid;
    int m_s1, m_wave;

    always @(posedge clk) begin : model
        int nxt;
        bit wrapnow;
        bit xfer;
        if (rst) begin
            m_acc = 0; m_step = 0; m_phase = 0; m_mode = 0;
            m_pend = 0; m_ready = 1; m_en1 = 0; m_valid = 0;
            m_s1 = 0; m_wave = 0;
        end else begin
            xfer = cfg_bus.cfg_valid && m_ready;
            if (m_en1) m_wave = m_s1;
            m_valid = m_en1;
            m_s1 = shape((m_acc + m_phase * (1 << (ACC_W - PHASE_W))) % MODV, m_mode);
            m_en1 = enable;
            nxt = m_acc + m_step;
            wrapnow = enable && (nxt >= MODV);
            if (enable) m_acc = nxt % MODV;
            if (m_pend) begin
                if (!enable || wrapnow || m_step == 0) begin
                    m_step = sh_step; m_phase = sh_phase; m_mode = sh_mode;
                    m_pend = 0; m_ready = 1;
                end
            end else if (xfer) begin
                if (!enable) begin
                    m_step = int'(cfg_bus.cfg_step);
                    m_phase = int'(cfg_bus.cfg_phase);
                    m_mode = int'(cfg_bus.cfg_mode);
                end else begin
                    sh_step = int'(cfg_bus.cfg_step);
                    sh_phase = int'(cfg_bus.cfg_phase);
                    sh_mode = int'(cfg_bus.cfg_mode);
                    m_pend = 1; m_ready = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_out_valid", 32'(out_valid), 32'(m_valid));
            check("model_wave_out", 32'(wave_out), 32'(m_wave));
            check("model_cfg_ready", 32'(cfg_bus.cfg_ready), 32'(m_ready));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic offer(input int step, input int phase, input int mode);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_step = ACC_W'(step);
        cfg_bus.cfg_phase = PHASE_W'(phase);
        cfg_bus.cfg_mode = mode_t'(mode);
    endtask

    // ---------------- test ----------------
    vec_t tbl[8];

    initial begin
        int low;
        int pulses;
        logic [OUT_W-1:0] e;

        tbl[0] = '{step: 16, phase: 0,  mode: 0, exp0: 0,   exp1: 1,   exp2: 2};
        tbl[1] = '{step: 32, phase: 0,  mode: 1, exp0: 0,   exp1: 4,   exp2: 8};
        tbl[2] = '{step: 16, phase: 8,  mode: 0, exp0: 128, exp1: 129, exp2: 130};
        tbl[3] = '{step: 16, phase: 8,  mode: 2, exp0: 255, exp1: 255, exp2: 255};
        tbl[4] = '{step: 16, phase: 0,  mode: 2, exp0: 0,   exp1: 0,   exp2: 0};
        tbl[5] = '{step: 48, phase: 5,  mode: 3, exp0: 128, exp1: 128, exp2: 128};
        tbl[6] = '{step: 32, phase: 8,  mode: 1, exp0: 255, exp1: 251, exp2: 247};
        tbl[7] = '{step: 16, phase: 15, mode: 0, exp0: 240, exp1: 241, exp2: 242};

        cfg_bus.cfg_step = '0;
        cfg_bus.cfg_phase = '0;
        cfg_bus.cfg_mode = MODE_SAW;
        do_reset();
        chk_on = 1'b1;

        // Reset state
        check("rst_wave_out", 32'(wave_out), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_cfg_ready", 32'(cfg_bus.cfg_ready), 1);
        check("rst_state", 32'(state), 32'(IDLE));

        // Directed table: config while idle, then run and inspect first samples
        for (int i = 0; i < 8; i++) begin
            do_reset();
            offer(tbl[i].step, tbl[i].phase, tbl[i].mode);
            tick(1);
            cfg_bus.cfg_valid = 1'b0;
            enable = 1'b1;
            tick(2);
            check($sformatf("tbl%0d_valid", i), 32'(out_valid), 1);
            check($sformatf("tbl%0d_s0", i), 32'(wave_out), 32'(tbl[i].exp0));
            tick(1);
            check($sformatf("tbl%0d_s1", i), 32'(wave_out), 32'(tbl[i].exp1));
            tick(1);
            check($sformatf("tbl%0d_s2", i), 32'(wave_out), 32'(tbl[i].exp2));
        end

        // Full sawtooth period with wrap, out_valid latency
        do_reset();
        offer(16, 0, 0);
        tick(1);
        cfg_bus.cfg_valid = 1'b0;
        enable = 1'b1;
        tick(1);
        check("saw_valid_lat1", 32'(out_valid), 0);
        tick(1);
        check("saw_valid_lat2", 32'(out_valid), 1);
        for (int k = 0; k <= 256; k++) exp_q.push_back(OUT_W'(k % 256));
        pulses = 0;
        for (int k = 0; k <= 256; k++) begin
            e = exp_q.pop_front();
            check("saw_period", 32'(wave_out), 32'(e));
`ifdef DDS_SYNC_OUT_EN
            if (sync_out) begin
                pulses++;
                check("sync_at_zero", 32'(wave_out), 0);
            end
`endif
            tick(1);
        end
`ifdef DDS_SYNC_OUT_EN
        check("sync_pulse_count", 32'(pulses), 2);
`endif

        // Mid-run config: transfer at acc=0x500, applied at the wrap
        do_reset();
        offer(16, 0, 0);
        tick(1);
        cfg_bus.cfg_valid = 1'b0;
        enable = 1'b1;
        tick(80);
        offer(32, 0, 0);
        tick(1);
        cfg_bus.cfg_valid = 1'b0;
        check("mid_state_pending", 32'(state), 32'(PENDING));
        low = 0;
        for (int i = 0; i < 400; i++) begin
            if (cfg_bus.cfg_ready) break;
            low++;
            tick(1);
        end
        check("mid_ready_low_cycles", 32'(low), 175);
        check("mid_pre_wrap_a", 32'(wave_out), 254);
        tick(1);
        check("mid_pre_wrap_b", 32'(wave_out), 255);
        tick(1);
        check("mid_post_wrap_a", 32'(wave_out), 0);
        tick(1);
        check("mid_post_wrap_b", 32'(wave_out), 2);
        tick(1);
        check("mid_post_wrap_c", 32'(wave_out), 4);

        // Zero step: no wrap possible, apply next cycle; then reset in PENDING
        do_reset();
        enable = 1'b1;
        offer(16, 0, 0);
        tick(1);
        cfg_bus.cfg_valid = 1'b0;
        check("zero_ready_low", 32'(cfg_bus.cfg_ready), 0);
        check("zero_state_pending", 32'(state), 32'(PENDING));
        tick(1);
        check("zero_ready_back", 32'(cfg_bus.cfg_ready), 1);
        check("zero_state_run", 32'(state), 32'(RUN));
        tick(5);
        offer(48, 3, 1);
        tick(1);
        cfg_bus.cfg_valid = 1'b0;
        check("pend_state", 32'(state), 32'(PENDING));
        check("pend_wave_nonzero", 32'(wave_out != 0), 1);
        rst = 1'b1;
        tick(1);
        check("rstpend_ready", 32'(cfg_bus.cfg_ready), 1);
        check("rstpend_wave", 32'(wave_out), 0);
        check("rstpend_valid", 32'(out_valid), 0);
        check("rstpend_state", 32'(state), 32'(IDLE));
        rst = 1'b0;
        tick(6);
        check("rstpend_shadow_dropped", 32'(wave_out), 0);
        check("rstpend_running", 32'(out_valid), 1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 5) == 0)
                offer($urandom_range(0, 400), $urandom_range(0, 15), $urandom_range(0, 3));
            else
                cfg_bus.cfg_valid = 1'b0;
            tick(1);
        end
        cfg_bus.cfg_valid = 1'b0;
        rst = 1'b0;
        tick(3);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dds_wave_gen.md
Name: dds_wave_gen

Overview:
Parametrised phase-accumulator waveform generator; next generation of the single-mode triangle source.
- Computes sawtooth, triangle, square or DC arithmetically from accumulator bits, so no ROM is needed.
- Frequency step, phase offset and mode arrive over a valid/ready config port.
- New config takes effect glitch-free at the next accumulator wrap.
- Sits between the control register block and the DAC output formatter.

Parameters:
ACC_W, 32, phase accumulator width (must be >= OUT_W+1)
PHASE_W, 12, phase offset width; offset is left-aligned onto accumulator MSBs
OUT_W, 16, unsigned output sample width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  accumulator advances while high
cfg_valid  in  1  config offer
cfg_ready  out  1  config slot free
cfg_step  in  ACC_W  frequency tuning word
cfg_phase  in  PHASE_W  phase offset
cfg_mode  in  2  0 saw, 1 triangle, 2 square, 3 DC midscale
wave_out  out  OUT_W  sample, unsigned
out_valid  out  1  wave_out holds a sample from an enabled cycle

Behaviour:
- Reset values: acc=0, active step/phase/mode=0, shadow empty, cfg_ready=1, wave_out=0, out_valid=0, FSM=IDLE.
- Reset asserted mid-operation drops any pending config and flushes the pipeline on the next edge.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready; the values are captured into shadow registers.
  - cfg_ready=0 while a shadow is pending.
  - cfg_valid without cfg_ready is ignored; there is no queue.
- FSM states and transitions:
  - IDLE (enable=0): accumulator holds. A transfer applies directly to the active registers next cycle; cfg_ready stays 1.
  - RUN (enable=1, no pending): acc <= (acc + step) mod 2^ACC_W. A transfer moves to PENDING.
  - PENDING: the shadow is copied to active on the first cycle whose acc+step carries out of ACC_W (wrap); return to RUN and cfg_ready=1 the next cycle.
  - PENDING also applies immediately if enable falls (-> IDLE) or if the active step==0, since a wrap can never occur.
  - A transfer in the same cycle as a wrap is applied at the following wrap, not this one.
- Phase: p = (acc + (phase << (ACC_W-PHASE_W))) mod 2^ACC_W.
- Shaping, with msb = p[ACC_W-1]:
  - saw: p[ACC_W-1 -: OUT_W]
  - triangle: t = p[ACC_W-2 -: OUT_W]; out = msb ? ~t : t
  - square: msb ? all-ones : 0
  - DC: 2^(OUT_W-1)
- Latency:
  - 2 cycles from an accumulator value to wave_out: stage 1 registers p and mode, stage 2 registers the shaped sample.
  - out_valid is enable delayed 2 cycles.
  - wave_out holds its last value while out_valid=0.
- Mode and phase change only via the wrap-aligned apply, so the output never shows a partial update.

Optional Feature:
DDS_SYNC_OUT_EN
- Defined: adds output port sync_out (1 bit, reset 0). It is a one-cycle pulse aligned with the wave_out sample computed from the first accumulator value after a wrap; it also pulses on the sample following a config apply.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package dds_pkg holds: mode localparams (MODE_SAW=0, MODE_TRI=1, MODE_SQR=2, MODE_DC=3), the FSM state encoding (IDLE, RUN, PENDING), and a 2-bit mode typedef.
- One sub-module, dds_wave_shaper: phase-to-sample mapping plus the stage-2 register, parameterised by ACC_W/OUT_W.
- The accumulator, FSM and handshake stay in dds_wave_gen.

Test Plan:
(ACC_W=12, PHASE_W=4, OUT_W=8 unless noted)
- Reset, transfer step=16 mode=0 while enable=0, then enable=1 -> out_valid rises 2 cycles later; wave_out 0,1,2,...,255,0 with a wrap every 256 cycles.
- Triangle: step=32, mode=1 -> wave_out 0,4,...,252,255,251,...,3,0; period 128 cycles.
- Phase offset: step=16, mode=0, phase=8 -> first valid sample 128; square mode with the same offset -> first sample 255, toggling every 128 cycles.
- Mid-run config: running step=16; transfer step=32 at acc=0x500 -> cfg_ready=0 until wrap; the samples before the wrap keep +1 spacing, the samples after it use +2; cfg_ready returns high the cycle after the apply.
- Zero step: active step=0 and enable=1, transfer step=16 -> applied the next cycle with no wrap wait; reset asserted during PENDING -> shadow dropped, cfg_ready=1, wave_out=0, out_valid=0.
- With DDS_SYNC_OUT_EN: step=16 -> sync_out pulses exactly once per 256 cycles, coincident with wave_out=0.
